line_psum_accumulator: RTL and testbench

- Downstream stage of the line KC-PE conv2d engine.
- Consumes the four per-kernel psum streams (kn0..kn3) and accumulates them into per-kernel line buffers, one entry per output position.
- Accumulation runs over a configurable number of passes (channel groups / kernel rows).
- After the last pass, the finished line is drained as one packed word per position to the output writer, using a valid/ready handshake.

---
 rtl/accel_pkg.sv | 21 ++
 rtl/psum_line_buf.sv | 76 +++++++
 rtl/line_psum_accumulator.sv | 169 ++++++++++++++++
 tb/tb_line_psum_accumulator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the line KC-PE accumulation stage: config word
// field positions, FSM state encoding and default accumulator width.
package accel_pkg;

  localparam int ACC_WIDTH_DEF = 20;

  // i_conf_ctrl field positions
  localparam int EN_BIT    = 0;
  localparam int CLR_BIT   = 1;
  localparam int NPASS_LSB = 8;
  localparam int NPASS_MSB = 15;
  localparam int LLEN_LSB  = 16;
  localparam int LLEN_MSB  = 23;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_DRAIN = 2'd2
  } acc_state_t;

endpackage

// File: rtl/psum_line_buf.sv
// Single-kernel line buffer: accumulates one psum stream over several passes
// with a single-cycle read-modify-write, and offers a registered read port.
module psum_line_buf
  import accel_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LINE_LEN  = 32,
  parameter int PW        = $clog2(LINE_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 accept,
  input  logic [PW-1:0]        llen_m1,
  input  logic [7:0]           npass_m1,
  input  logic [BIT_WIDTH-1:0] psum,
  input  logic                 psum_val,
  input  logic                 rd_en,
  input  logic [PW-1:0]        rd_addr,
  output logic [ACC_WIDTH-1:0] rd_data,
  output logic                 done,
  output logic                 done_nxt
);

  logic [ACC_WIDTH-1:0] mem [LINE_LEN];
  logic [PW-1:0]        wp;
  logic [7:0]           pc;
  logic                 done_q;
  logic                 wr;
  logic                 wrap;
  logic                 last;
  logic [ACC_WIDTH-1:0] sum;

  assign wr       = psum_val && accept && !done_q;
  assign wrap     = (wp == llen_m1);
  assign last     = wrap && (pc == npass_m1);
  // First pass overwrites whatever the previous line left behind.
  assign sum      = ((pc == 8'd0) ? '0 : mem[wp]) +
                    {{(ACC_WIDTH-BIT_WIDTH){psum[BIT_WIDTH-1]}}, psum};
  assign done     = done_q;
  assign done_nxt = done_q || (wr && last);

  // Buffer storage write (contents need no reset)
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= sum;
  end

  // Write pointer, pass counter and done flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp     <= '0;
      pc     <= '0;
      done_q <= 1'b0;
    end else if (init) begin
      wp     <= '0;
      pc     <= '0;
      done_q <= 1'b0;
    end else if (wr) begin
      if (wrap) begin
        wp <= '0;
        pc <= pc + 8'd1;
        if (last) done_q <= 1'b1;
      end else begin
        wp <= wp + PW'(1);
      end
    end
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_psum_accumulator.sv
// Accumulates four independent per-kernel psum streams into line buffers over
// npass passes, then drains one packed word per position downstream.
// Output handshake: a word transfers on a cycle where o_acc_val and i_acc_rdy
// are both high; while o_acc_val=1 and i_acc_rdy=0, o_acc and o_acc_val hold.
module line_psum_accumulator
  import accel_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int NUM_KERNEL = 4,
  parameter int LINE_LEN   = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn0,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn1,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn2,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn3,
  input  logic                            i_psum_kn0_val,
  input  logic                            i_psum_kn1_val,
  input  logic                            i_psum_kn2_val,
  input  logic                            i_psum_kn3_val,
  output logic                            o_psum_rdy,
  input  logic [REG_WIDTH-1:0]            i_conf_ctrl,
  output logic [ACC_WIDTH*NUM_KERNEL-1:0] o_acc,
  output logic                            o_acc_val,
  input  logic                            i_acc_rdy,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err_overrun,
  output acc_state_t                      o_dbg_state
);

  localparam int          PW     = $clog2(LINE_LEN);
  localparam logic [8:0]  LL_MAX = 9'(LINE_LEN);

  acc_state_t             state, state_nxt;
  logic [PW-1:0]          llen_m1;
  logic [7:0]             npass_m1;
  logic [PW-1:0]          rp;
  logic [PW-1:0]          rd_addr;
  logic                   rd_en;
  logic                   init;
  logic                   accept;
  logic                   hs;
  logic                   last_rp;
  logic                   clr;
  logic                   en;
  logic [7:0]             cf_npass;
  logic [7:0]             cf_llen;
  logic [BIT_WIDTH-1:0]   psum_a [NUM_KERNEL];
  logic [NUM_KERNEL-1:0]  val_a;
  logic [NUM_KERNEL-1:0]  done_a;
  logic [NUM_KERNEL-1:0]  done_nxt_a;
  logic [NUM_KERNEL-1:0]  drop_a;
  logic [ACC_WIDTH-1:0]   rd_data [NUM_KERNEL];
  logic                   unused_conf;

  assign clr         = i_conf_ctrl[CLR_BIT];
  assign en          = i_conf_ctrl[EN_BIT];
  assign cf_npass    = i_conf_ctrl[NPASS_MSB:NPASS_LSB];
  assign cf_llen     = i_conf_ctrl[LLEN_MSB:LLEN_LSB];
  assign unused_conf = ^{i_conf_ctrl[REG_WIDTH-1:LLEN_MSB+1],
                         i_conf_ctrl[NPASS_LSB-1:CLR_BIT+1]};

  assign psum_a[0] = i_psum_kn0;
  assign psum_a[1] = i_psum_kn1;
  assign psum_a[2] = i_psum_kn2;
  assign psum_a[3] = i_psum_kn3;
  assign val_a     = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

  assign hs          = o_acc_val && i_acc_rdy;
  assign last_rp     = (rp == llen_m1);
  assign o_dbg_state = state;

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_kn
    psum_line_buf #(
      .BIT_WIDTH (BIT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .LINE_LEN  (LINE_LEN),
      .PW        (PW)
    ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .init     (init),
      .accept   (accept),
      .llen_m1  (llen_m1),
      .npass_m1 (npass_m1),
      .psum     (psum_a[k]),
      .psum_val (val_a[k]),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[k]),
      .done     (done_a[k]),
      .done_nxt (done_nxt_a[k])
    );
    assign o_acc[k*ACC_WIDTH +: ACC_WIDTH] = rd_data[k];
    // A valid is dropped unless its kernel is still accumulating
    assign drop_a[k] = val_a[k] && !((state == ACC_ACCUM) && !done_a[k]);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACC_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic; soft clear overrides everything
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC_IDLE;
    end else begin
      unique case (state)
        ACC_IDLE:  if (en)            state_nxt = ACC_ACCUM;
        ACC_ACCUM: if (&done_nxt_a)   state_nxt = ACC_DRAIN;
        ACC_DRAIN: if (hs && last_rp) state_nxt = ACC_IDLE;
        default:                      state_nxt = ACC_IDLE;
      endcase
    end
  end

  // FSM outputs; on a handshake the next word is read at once so words can
  // stream back-to-back when the consumer is always ready
  always_comb begin
    o_psum_rdy = (state == ACC_ACCUM);
    o_busy     = (state != ACC_IDLE);
    accept     = (state == ACC_ACCUM) && !clr;
    init       = clr || (state == ACC_IDLE);
    rd_en      = (state == ACC_DRAIN) && !clr &&
                 (!o_acc_val || (hs && !last_rp));
    rd_addr    = o_acc_val ? (rp + PW'(1)) : rp;
  end

  // Config latch on IDLE->ACCUM with zero/oversize fields normalised
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      npass_m1 <= '0;
      llen_m1  <= '0;
    end else if ((state == ACC_IDLE) && en && !clr) begin
      npass_m1 <= (cf_npass == 8'd0) ? 8'd0 : (cf_npass - 8'd1);
      if ((cf_llen == 8'd0) || ({1'b0, cf_llen} > LL_MAX))
        llen_m1 <= PW'(LINE_LEN - 1);
      else
        llen_m1 <= PW'(cf_llen - 8'd1);
    end
  end

  // Drain pointer, output valid, done pulse and sticky overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp            <= '0;
      o_acc_val     <= 1'b0;
      o_done        <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      o_done <= !clr && (state == ACC_DRAIN) && hs && last_rp;
      if (clr || (state != ACC_DRAIN)) rp <= '0;
      else if (hs)                     rp <= rp + PW'(1);
      if (clr)        o_acc_val <= 1'b0;
      else if (rd_en) o_acc_val <= 1'b1;
      else if (hs)    o_acc_val <= 1'b0;
      if (clr)          o_err_overrun <= 1'b0;
      else if (|drop_a) o_err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_psum_accumulator.sv
// Self-checking bench for line_psum_accumulator: drives per-kernel psum
// streams, models the expected drained words in a queue and compares them
// against the DUT output as it drains.
module tb_line_psum_accumulator;
  import accel_pkg::*;

  localparam int W = 80;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   psum [4];
  logic [3:0]   pval = '0;
  logic         o_psum_rdy;
  logic [31:0]  conf = '0;
  logic [W-1:0] o_acc;
  logic         o_acc_val;
  logic         i_acc_rdy = 1'b1;
  logic         o_busy;
  logic         o_done;
  logic         o_err_overrun;
  acc_state_t   dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  int           rdy_mode = 0;
  int           bp_cnt = 2;
  bit           mon_en = 1'b1;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_acc = '0;
  logic [7:0]   stim [4][8][32];
  int           skew [4] = '{0, 0, 0, 0};

  line_psum_accumulator dut (
    .clk            (clk),
    .rst            (rst),
    .i_psum_kn0     (psum[0]),
    .i_psum_kn1     (psum[1]),
    .i_psum_kn2     (psum[2]),
    .i_psum_kn3     (psum[3]),
    .i_psum_kn0_val (pval[0]),
    .i_psum_kn1_val (pval[1]),
    .i_psum_kn2_val (pval[2]),
    .i_psum_kn3_val (pval[3]),
    .o_psum_rdy     (o_psum_rdy),
    .i_conf_ctrl    (conf),
    .o_acc          (o_acc),
    .o_acc_val      (o_acc_val),
    .i_acc_rdy      (i_acc_rdy),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err_overrun  (o_err_overrun),
    .o_dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready generator: 0 = always ready, 1 = 0,0,1 per word, 2 = stalled
  always @(posedge clk) begin
    #1;
    if (o_acc_val) bp_cnt = (bp_cnt + 1) % 3;
    i_acc_rdy = (rdy_mode == 0) || (rdy_mode == 1 && bp_cnt == 2);
  end

  // Output monitor: hold rule and scoreboard comparison
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (rst && mon_en) begin
      if (prev_stall) begin
        check("hold_acc", o_acc, prev_acc);
        check("hold_val", W'(o_acc_val), W'(1));
      end
      if (o_acc_val && i_acc_rdy) begin
        if (exp_q.size() == 0) check("sb_underflow", W'(exp_q.size()), W'(1));
        else                   check("word", o_acc, exp_q.pop_front());
      end
      prev_stall = o_acc_val && !i_acc_rdy;
      prev_acc   = o_acc;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a line, compute the expected words, drive the skewed streams
  task automatic feed(input int np, input int ll);
    logic [19:0]  m [4][32];
    logic [W-1:0] w;
    int npe, lle, tot, maxs, i;
    npe  = (np == 0) ? 1 : np;
    lle  = (ll == 0 || ll > 32) ? 32 : ll;
    tot  = npe * lle;
    maxs = 0;
    for (int k = 0; k < 4; k++) if (skew[k] > maxs) maxs = skew[k];
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < lle; p++) begin
        m[k][p] = '0;
        for (int q = 0; q < npe; q++)
          m[k][p] = m[k][p] + {{12{stim[k][q][p][7]}}, stim[k][q][p]};
      end
    for (int p = 0; p < lle; p++) begin
      for (int k = 0; k < 4; k++) w[k*20 +: 20] = m[k][p];
      exp_q.push_back(w);
    end
    step();
    conf = 32'h1 | (32'(np & 255) << 8) | (32'(ll & 255) << 16);
    step();
    conf = '0;
    check("rdy_accum", W'(o_psum_rdy), W'(1));
    for (int t = 0; t < tot + maxs; t++) begin
      for (int k = 0; k < 4; k++) begin
        i = t - skew[k];
        if (i >= 0 && i < tot) begin
          pval[k] = 1'b1;
          psum[k] = stim[k][i / lle][i % lle];
        end else begin
          pval[k] = 1'b0;
        end
      end
      if (t == tot + maxs - 1) check("rdy_last_write", W'(o_psum_rdy), W'(1));
      step();
    end
    pval = '0;
    check("rdy_drain", W'(o_psum_rdy), W'(0));
    check("state_drain", W'(dbg_state), W'(ACC_DRAIN));
  endtask

  // Wait for the done pulse of the current line and check the end state
  task automatic finish_line(input int exp_done);
    bit seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check("done_seen", W'(seen), W'(1));
    @(negedge clk);
    check("done_once", W'(done_cnt), W'(exp_done));
    check("busy_end", W'(o_busy), W'(0));
    check("state_idle", W'(dbg_state), W'(ACC_IDLE));
    check("sb_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic rand_stim();
    for (int k = 0; k < 4; k++)
      for (int q = 0; q < 8; q++)
        for (int p = 0; p < 32; p++) stim[k][q][p] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int dc;
    int np_r, ll_r;
    psum = '{8'd0, 8'd0, 8'd0, 8'd0};
    repeat (3) @(posedge clk);
    // reset state
    #1;
    check("rst_acc", o_acc, W'(0));
    check("rst_acc_val", W'(o_acc_val), W'(0));
    check("rst_psum_rdy", W'(o_psum_rdy), W'(0));
    check("rst_busy", W'(o_busy), W'(0));
    check("rst_done", W'(o_done), W'(0));
    check("rst_err", W'(o_err_overrun), W'(0));
    rst = 1'b1;
    step();

    // npass=1, linelen=4, lanes 1..4
    rand_stim();
    for (int k = 0; k < 4; k++) for (int p = 0; p < 4; p++) stim[k][0][p] = 8'(p + 1);
    feed(1, 4);
    finish_line(1);

    // npass=3, linelen=2, kn0 10,20 each pass
    rand_stim();
    for (int q = 0; q < 3; q++) begin stim[0][q][0] = 8'd10; stim[0][q][1] = 8'd20; end
    feed(3, 2);
    finish_line(2);

    // kn2 -128 twice, npass=2, linelen=1
    rand_stim();
    stim[2][0][0] = 8'h80;
    stim[2][1][0] = 8'h80;
    feed(2, 1);
    finish_line(3);

    // kn3 lags kn0 by 5 cycles
    rand_stim();
    skew = '{0, 2, 1, 5};
    feed(2, 4);
    finish_line(4);

    // backpressure 0,0,1 per word
    rand_stim();
    skew = '{0, 0, 0, 0};
    bp_cnt = 2;
    rdy_mode = 1;
    feed(1, 4);
    finish_line(5);
    rdy_mode = 0;

    // npass=0 -> 1 pass, linelen=40 -> full line
    rand_stim();
    feed(0, 40);
    finish_line(6);

    // a few random lines with random skew and backpressure
    for (int r = 0; r < 3; r++) begin
      rand_stim();
      np_r = $urandom_range(1, 4);
      ll_r = $urandom_range(1, 9);
      for (int k = 0; k < 4; k++) skew[k] = $urandom_range(0, 3);
      bp_cnt = 2;
      rdy_mode = r % 2;
      feed(np_r, ll_r);
      finish_line(7 + r);
    end
    rdy_mode = 0;
    skew = '{0, 0, 0, 0};

    // valid in DRAIN sets the overrun flag, data unaffected, then soft clear
    rand_stim();
    rdy_mode = 2;
    feed(1, 4);
    check("err_before", W'(o_err_overrun), W'(0));
    psum[1] = 8'h55;
    pval[1] = 1'b1;
    step();
    pval = '0;
    check("err_drain", W'(o_err_overrun), W'(1));
    bp_cnt = 2;
    rdy_mode = 1;
    for (int c = 0; c < 100 && exp_q.size() > 2; c++) @(negedge clk);
    check("drained_two", W'(exp_q.size()), W'(2));
    mon_en = 1'b0;
    rdy_mode = 2;
    dc = done_cnt;
    step();
    conf = 32'h2;
    step();
    conf = '0;
    check("clr_err", W'(o_err_overrun), W'(0));
    check("clr_state", W'(dbg_state), W'(ACC_IDLE));
    check("clr_acc_val", W'(o_acc_val), W'(0));
    check("clr_busy", W'(o_busy), W'(0));
    repeat (3) step();
    check("clr_no_done", W'(done_cnt), W'(dc));
    exp_q.delete();
    mon_en = 1'b1;

    // async reset mid-DRAIN
    rand_stim();
    feed(1, 4);
    for (int c = 0; c < 20 && !o_acc_val; c++) @(negedge clk);
    check("pre_rst_val", W'(o_acc_val), W'(1));
    mon_en = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_acc_val", W'(o_acc_val), W'(0));
    check("arst_busy", W'(o_busy), W'(0));
    check("arst_acc", o_acc, W'(0));
    check("arst_state", W'(dbg_state), W'(ACC_IDLE));
    exp_q.delete();
    step();
    rst = 1'b1;
    rdy_mode = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
